// File: rtl/sbox_round_sched.sv
// Time-multiplexes one shared DES S-box lookup unit across the eight S-box
// positions of a round: issues eight 6-bit lookups and gathers the 32-bit result.
module sbox_round_sched #(
    parameter int unsigned LOOKUP_LAT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:48] in_data,
    output logic [2:0]  sbox_sel,
    output logic [1:6]  sbox_in,
    input  logic [1:4]  sbox_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:32] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:48] shadow;
    logic [2:0]  issue_cnt;
    logic [2:0]  cap_cnt;
    logic        cap_vld;
    logic [2:0]  cap_idx;
    logic [1:6]  next_field;
    logic        accept;
    logic        last_cap;

    assign accept   = in_valid & in_ready;
    assign last_cap = cap_vld & (cap_cnt == 3'd7);
    assign busy     = (state != IDLE);

    // Address field for the lookup following the current one.
    always_comb begin
        next_field = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            if (issue_cnt + 3'd1 == 3'(j))
                next_field = shadow[6*j+1 +: 6];
        end
    end

    // Capture strobe: the issue cycle itself, or the tail of the index delay line.
    generate
        if (LOOKUP_LAT == 0) begin : g_comb_lookup
            assign cap_vld = (state == ISSUE);
            assign cap_idx = issue_cnt;
        end else begin : g_reg_lookup
            logic [LOOKUP_LAT-1:0] dly_vld;
            logic [2:0]            dly_idx [LOOKUP_LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dly_vld <= '0;
                    for (int unsigned i = 0; i < LOOKUP_LAT; i++)
                        dly_idx[i] <= '0;
                end else begin
                    dly_vld[0] <= (state == ISSUE);
                    dly_idx[0] <= issue_cnt;
                    for (int unsigned i = 1; i < LOOKUP_LAT; i++) begin
                        dly_vld[i] <= dly_vld[i-1];
                        dly_idx[i] <= dly_idx[i-1];
                    end
                end
            end

            assign cap_vld = dly_vld[LOOKUP_LAT-1];
            assign cap_idx = dly_idx[LOOKUP_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                if (issue_cnt == 3'd7)
                    state_nxt = (LOOKUP_LAT == 0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (last_cap)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            sbox_sel  <= '0;
            sbox_in   <= '0;
            out_data  <= '0;
        end else if (accept) begin
            // First lookup is presented straight from the input word.
            shadow    <= in_data;
            out_data  <= '0;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            sbox_sel  <= '0;
            sbox_in   <= in_data[1:6];
        end else begin
            if (state == ISSUE) begin
                issue_cnt <= issue_cnt + 3'd1;
                if (issue_cnt != 3'd7) begin
                    sbox_sel <= issue_cnt + 3'd1;
                    sbox_in  <= next_field;
                end
            end
            if (cap_vld) begin
                cap_cnt <= cap_cnt + 3'd1;
                for (int unsigned j = 0; j < 8; j++) begin
                    if (cap_idx == 3'(j))
                        out_data[4*j+1 +: 4] <= sbox_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_sbox_round_sched.sv
// Bench for sbox_round_sched: a combinational-table instance and a two-cycle
// registered-table instance, each fed by a DES S-box model with junk between lookups.
module tb_sbox_round_sched;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        drv_valid = 1'b0;
    logic        use2      = 1'b0;
    logic        out_ready = 1'b1;
    logic [47:0] in_data   = '0;

    logic        in_valid0, in_ready0, out_valid0, busy0;
    logic [2:0]  sel0;
    logic [5:0]  sin0;
    logic [3:0]  sout0;
    logic [31:0] od0;
    logic        in_valid2, in_ready2, out_valid2, busy2;
    logic [2:0]  sel2;
    logic [5:0]  sin2;
    logic [3:0]  sout2;
    logic [31:0] od2;

    assign in_valid0 = drv_valid & ~use2;
    assign in_valid2 = drv_valid & use2;

    sbox_round_sched #(.LOOKUP_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data),
        .sbox_sel(sel0), .sbox_in(sin0), .sbox_out(sout0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(od0), .busy(busy0));

    sbox_round_sched #(.LOOKUP_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data),
        .sbox_sel(sel2), .sbox_in(sin2), .sbox_out(sout2), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(od2), .busy(busy2));

    int unsigned sbox_tab [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    // DES addressing: outer bits pick the row, inner four bits the column.
    function automatic logic [3:0] sbox_ref(input int unsigned t, input logic [5:0] a);
        int unsigned row, col;
        row = 2 * int'(a[5]) + int'(a[0]);
        col = int'(a[4:1]);
        return 4'(sbox_tab[t][row*16 + col]);
    endfunction

    function automatic logic [31:0] round_ref(input logic [47:0] d);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++)
            r[31-4*k -: 4] = sbox_ref(k, d[47-6*k -: 6]);
        return r;
    endfunction

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic        c_in_ready, c_out_valid, c_busy;
    logic [2:0]  c_sel;
    logic [5:0]  c_sin;
    logic [31:0] c_od;
    int unsigned c_lat;

    always_comb begin
        c_in_ready  = use2 ? in_ready2  : in_ready0;
        c_out_valid = use2 ? out_valid2 : out_valid0;
        c_busy      = use2 ? busy2      : busy0;
        c_sel       = use2 ? sel2       : sel0;
        c_sin       = use2 ? sin2       : sin0;
        c_od        = use2 ? od2        : od0;
        c_lat       = use2 ? 2 : 0;
    end

    // Lookup responders: valid data only for the eight issue cycles of a word.
    int          iss_left = 0;
    logic [3:0]  junk = 4'h5;
    logic [3:0]  p1 = '0;
    logic [3:0]  p2 = '0;
    assign sout0 = (!use2 && iss_left > 0) ? sbox_ref(int'(sel0), sin0) : junk;
    assign sout2 = p2;

    int unsigned cyc = 0;
    int unsigned acc_cnt = 0;
    int unsigned hs_cnt = 0;
    int unsigned acc_cyc = 0;
    bit          seen_valid = 1'b0;
    logic [47:0] cur_word = '0;
    int unsigned acc_hist [$];
    logic [31:0] outq [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_left   <= 0;
            p1         <= 4'($urandom);
            p2         <= 4'($urandom);
            seen_valid = 1'b1;
        end else begin
            cyc  <= cyc + 1;
            junk <= 4'($urandom);
            p2   <= p1;
            p1   <= (use2 && iss_left > 0) ? sbox_ref(int'(sel2), sin2) : 4'($urandom);
            if (iss_left > 0) begin
                chk("issue_sel", 64'(c_sel), 64'(8 - iss_left));
                chk("issue_in", 64'(c_sin), 64'(cur_word[47-6*(8-iss_left) -: 6]));
            end
            if (c_out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                chk("latency", 64'(cyc - acc_cyc), 64'(9 + c_lat));
            end
            if (c_out_valid && out_ready) begin
                hs_cnt++;
                outq.push_back(c_od);
            end
            if (drv_valid && c_in_ready) begin
                acc_cnt++;
                acc_cyc  = cyc;
                acc_hist.push_back(cyc);
                cur_word = in_data;
                seen_valid = 1'b0;
                iss_left <= 8;
            end else if (iss_left > 0) begin
                iss_left <= iss_left - 1;
            end
        end
    end

    task automatic wait_acc(input int unsigned n);
        for (int i = 0; i < 100 && acc_cnt < n; i++) @(negedge clk);
        chk("accept_wait", 64'(acc_cnt), 64'(n));
    endtask

    task automatic wait_hs(input int unsigned n);
        for (int i = 0; i < 200 && hs_cnt < n; i++) @(negedge clk);
        chk("handshake_wait", 64'(hs_cnt), 64'(n));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 64'(c_in_ready), 64'(1));
        chk({tag, "_out_valid"}, 64'(c_out_valid), 64'(0));
        chk({tag, "_busy"}, 64'(c_busy), 64'(0));
        chk({tag, "_sel"}, 64'(c_sel), 64'(0));
        chk({tag, "_sbox_in"}, 64'(c_sin), 64'(0));
        chk({tag, "_out_data"}, 64'(c_od), 64'(0));
    endtask

    task automatic run_word(input bit u, input logic [47:0] d, input logic [31:0] exp,
                            input string name);
        int unsigned a0, h0;
        @(negedge clk);
        use2 = u; in_data = d; out_ready = 1'b1; drv_valid = 1'b1;
        a0 = acc_cnt; h0 = hs_cnt;
        wait_acc(a0 + 1);
        drv_valid = 1'b0;
        wait_hs(h0 + 1);
        chk({name, "_in_ready_after"}, 64'(c_in_ready), 64'(1));
        chk({name, "_valid_after"}, 64'(c_out_valid), 64'(0));
        chk({name, "_busy_after"}, 64'(c_busy), 64'(0));
        if (outq.size() > 0) chk({name, "_data"}, 64'(outq[$]), 64'(exp));
        else chk({name, "_data_count"}, 64'(0), 64'(1));
    endtask

    typedef struct {
        bit          u;
        logic [47:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [8];

    initial begin
        int unsigned a0, h0, q0, o0;
        logic [31:0] held;
        logic [47:0] r;
        bit          saw;

        vt[0] = '{1'b0, 48'h0,            32'hEFA72C4D};
        vt[1] = '{1'b0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
        vt[2] = '{1'b1, 48'h0,            32'hEFA72C4D};
        vt[3] = '{1'b1, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
        for (int i = 4; i < 8; i++) begin
            r = {$urandom, 16'($urandom)};
            vt[i] = '{1'(i % 2), r, round_ref(r)};
        end

        #1 rst = 1'b1;
        #2 use2 = 1'b0;
        #0 chk_reset("reset0");
        use2 = 1'b1;
        #0 chk_reset("reset2");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_word(vt[i].u, vt[i].d, vt[i].exp, $sformatf("vec%0d", i));

        // Backpressure on the registered-table instance.
        @(negedge clk);
        use2 = 1'b1; in_data = '0; out_ready = 1'b0; drv_valid = 1'b1;
        a0 = acc_cnt; h0 = hs_cnt;
        wait_acc(a0 + 1);
        drv_valid = 1'b0;
        for (int i = 0; i < 40 && !c_out_valid; i++) @(negedge clk);
        chk("bp_valid_rise", 64'(c_out_valid), 64'(1));
        held = c_od;
        chk("bp_data", 64'(held), 64'(32'hEFA72C4D));
        for (int i = 0; i < 20; i++) begin
            drv_valid = (i % 4 == 1);
            @(negedge clk);
            chk("bp_hold_valid", 64'(c_out_valid), 64'(1));
            chk("bp_hold_data", 64'(c_od), 64'(held));
            chk("bp_hold_in_ready", 64'(c_in_ready), 64'(0));
        end
        chk("bp_sel_held", 64'(c_sel), 64'(7));
        chk("bp_no_accept", 64'(acc_cnt), 64'(a0 + 1));
        chk("bp_no_handshake", 64'(hs_cnt), 64'(h0));
        drv_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_hs", 64'(hs_cnt), 64'(h0 + 1));
        chk("bp_release_valid", 64'(c_out_valid), 64'(0));
        chk("bp_release_in_ready", 64'(c_in_ready), 64'(1));
        repeat (5) @(negedge clk);
        chk("bp_single_hs", 64'(hs_cnt), 64'(h0 + 1));
        chk("bp_nothing_queued", 64'(acc_cnt), 64'(a0 + 1));
        chk("bp_idle", 64'(c_busy), 64'(0));

        // Asynchronous reset during issue step 4.
        @(negedge clk);
        use2 = 1'b0; in_data = '0; out_ready = 1'b1; drv_valid = 1'b1;
        a0 = acc_cnt;
        wait_acc(a0 + 1);
        drv_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_at_k4_sel", 64'(c_sel), 64'(4));
        #2 rst = 1'b1;
        #1 chk_reset("mid_reset");
        @(posedge clk);
        #2 rst = 1'b0;
        h0 = hs_cnt; saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (c_out_valid) saw = 1'b1;
        end
        chk("rst_no_valid", 64'(saw), 64'(0));
        chk("rst_no_handshake", 64'(hs_cnt), 64'(h0));
        run_word(1'b0, 48'h0, 32'hEFA72C4D, "post_reset");

        // Back-to-back words with in_valid held high.
        @(negedge clk);
        use2 = 1'b0; in_data = '0; out_ready = 1'b1; drv_valid = 1'b1;
        a0 = acc_cnt; h0 = hs_cnt;
        q0 = acc_hist.size(); o0 = outq.size();
        wait_acc(a0 + 1);
        in_data = 48'hFFFFFFFFFFFF;
        wait_acc(a0 + 2);
        drv_valid = 1'b0;
        wait_hs(h0 + 2);
        if (acc_hist.size() >= q0 + 2)
            chk("b2b_spacing", 64'(acc_hist[q0+1] - acc_hist[q0]), 64'(10));
        else
            chk("b2b_accepts", 64'(acc_hist.size()), 64'(q0 + 2));
        if (outq.size() >= o0 + 2) begin
            chk("b2b_out0", 64'(outq[o0]), 64'(32'hEFA72C4D));
            chk("b2b_out1", 64'(outq[o0+1]), 64'(32'hD9CE3DCB));
        end else begin
            chk("b2b_outputs", 64'(outq.size()), 64'(o0 + 2));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
